dll_update_ctrl: RTL and testbench

Synthesizable controller for the master side of the DLL delay-code interface: it watches DLL lock, drives the DLL's UDDCNTL/ALUHOLD update controls, and waits until the 6-bit delay code is stable. It then applies a signed user offset, saturates the result and publishes the code to downstream slave delay lines, but only during a safe idle window. It sits between the DLL primitive and the DQS/slave-delay consumers.

---
 rtl/dll_update_pkg.sv | 47 ++++
 rtl/dll_lock_filter.sv | 38 +++
 rtl/dll_update_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dll_update_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dll_update_pkg.sv
// Shared types and helpers for the DLL delay-code update controller.
// Optional Gray-coded input path: DLL_UPDATE_CTRL_GRAY_EN.
package dll_update_pkg;

    localparam int CODE_W   = 6;
    localparam int DELADJ_W = 5;
    localparam int CODE_MAX = (1 << CODE_W) - 1;

    typedef enum logic [2:0] {
        ST_UNLOCKED,
        ST_WAIT_STABLE,
        ST_HOLD,
        ST_UPDATE,
        ST_TRACK
    } state_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              sat;
    } clamp_t;

    // One guard bit above the 7-bit range keeps 63+31 from wrapping negative.
    function automatic clamp_t clamp_code(input logic signed [CODE_W+1:0] sum);
        clamp_t r;
        if (sum < 0) begin
            r.code = '0;
            r.sat  = 1'b1;
        end else if (sum > CODE_MAX) begin
            r.code = '1;
            r.sat  = 1'b1;
        end else begin
            r.code = sum[CODE_W-1:0];
            r.sat  = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
        logic [CODE_W-1:0] b;
        b[CODE_W-1] = g[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/dll_lock_filter.sv
// DLL lock synchronizer and debounce filter.
// lock_o rises after LOCK_FILTER consecutive synchronized-high cycles.
module dll_lock_filter
    import dll_update_pkg::*;
#(
    parameter int LOCK_FILTER = 8
) (
    input  logic CLKIB,
    input  logic resetn,
    input  logic lock_i,
    output logic lock_o
);

    localparam logic [7:0] LF_C = 8'(LOCK_FILTER);

    logic       sync1;
    logic       sync2;
    logic [7:0] cnt;

    always_ff @(posedge CLKIB or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= lock_i;
            sync2 <= sync1;
            if (!sync2) begin
                cnt <= '0;
            end else if (cnt != LF_C) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign lock_o = (cnt == LF_C);

endmodule

// File: rtl/dll_update_ctrl.sv
// Master-side DLL code update controller: lock filter, stability wait,
// UDDCNTL/ALUHOLD sequencing, offset + clamp. Macro: DLL_UPDATE_CTRL_GRAY_EN.
module dll_update_ctrl
    import dll_update_pkg::*;
#(
    parameter int STABLE_CNT      = 4,
    parameter int LOCK_FILTER     = 8,
    parameter int UPDATE_INTERVAL = 1024
) (
    input  logic                CLKIB,
    input  logic                resetn,
    input  logic                lock_i,
    input  logic [CODE_W-1:0]   dcntl_i,
    input  logic                upd_req_i,
    input  logic                idle_i,
    input  logic [DELADJ_W-1:0] deladj_i,
    input  logic                deladjpol_i,
    output logic                uddcntl_o,
    output logic                aluhold_o,
    output logic [CODE_W-1:0]   code_o,
    output logic                code_vld_o,
    output logic                code_upd_o,
    output logic                lock_o,
    output logic                err_sat_o
);

    localparam logic [7:0]  STAB_TH  = 8'(STABLE_CNT - 1);
    localparam logic [15:0] IVL_LAST = 16'(UPDATE_INTERVAL - 1);

    state_t                   state_q;
    state_t                   state_d;
    logic [CODE_W-1:0]        dcntl_q;
    logic [CODE_W-1:0]        cur_code;
    logic [CODE_W-1:0]        prev_code;
    logic [CODE_W-1:0]        code_q;
    logic [7:0]               stab_cnt;
    logic [15:0]              ivl_cnt;
    logic                     stable;
    logic                     commit;
    logic signed [CODE_W+1:0] sum;
    clamp_t                   clamped;
    logic                     vld_q;
    logic                     upd_q;
    logic                     sat_q;

    dll_lock_filter #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_filter (
        .CLKIB  (CLKIB),
        .resetn (resetn),
        .lock_i (lock_i),
        .lock_o (lock_o)
    );

    always_ff @(posedge CLKIB or negedge resetn) begin
        if (!resetn) begin
            dcntl_q <= '0;
        end else begin
            dcntl_q <= dcntl_i;
        end
    end

`ifdef DLL_UPDATE_CTRL_GRAY_EN
    logic [CODE_W-1:0] bin_q;

    always_ff @(posedge CLKIB or negedge resetn) begin
        if (!resetn) begin
            bin_q <= '0;
        end else begin
            bin_q <= gray2bin(dcntl_q);
        end
    end

    assign cur_code = bin_q;
`else
    assign cur_code = dcntl_q;
`endif

    always_ff @(posedge CLKIB or negedge resetn) begin
        if (!resetn) begin
            prev_code <= '0;
            stab_cnt  <= '0;
        end else begin
            prev_code <= cur_code;
            if (cur_code != prev_code) begin
                stab_cnt <= '0;
            end else if (stab_cnt != 8'hff) begin
                stab_cnt <= stab_cnt + 8'd1;
            end
        end
    end

    assign stable = (stab_cnt >= STAB_TH);

    always_ff @(posedge CLKIB or negedge resetn) begin
        if (!resetn) begin
            ivl_cnt <= '0;
        end else if (state_q != ST_TRACK) begin
            ivl_cnt <= '0;
        end else begin
            ivl_cnt <= ivl_cnt + 16'd1;
        end
    end

    always_ff @(posedge CLKIB or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aluhold_o = 1'b0;
        uddcntl_o = 1'b0;
        unique case (state_q)
            ST_UNLOCKED: begin
                if (lock_o) state_d = ST_WAIT_STABLE;
            end
            ST_WAIT_STABLE: begin
                if (stable && idle_i) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                aluhold_o = 1'b1;
                state_d   = ST_UPDATE;
            end
            ST_UPDATE: begin
                aluhold_o = 1'b1;
                uddcntl_o = 1'b1;
                state_d   = ST_TRACK;
            end
            ST_TRACK: begin
                if (ivl_cnt == IVL_LAST || upd_req_i) begin
                    state_d = ST_WAIT_STABLE;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
        // Lock loss overrides every transition.
        if (!lock_o) state_d = ST_UNLOCKED;
    end

    always_comb begin
        sum = $signed({2'b00, cur_code});
        if (deladjpol_i) begin
            sum = sum - $signed({3'b000, deladj_i});
        end else begin
            sum = sum + $signed({3'b000, deladj_i});
        end
        clamped = clamp_code(sum);
    end

    assign commit = (state_q == ST_UPDATE) && lock_o;

    always_ff @(posedge CLKIB or negedge resetn) begin
        if (!resetn) begin
            code_q <= '0;
            vld_q  <= 1'b0;
            upd_q  <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            upd_q <= commit;
            if (commit) begin
                code_q <= clamped.code;
                vld_q  <= 1'b1;
                if (clamped.sat) sat_q <= 1'b1;
            end else if (!lock_o) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign code_o     = code_q;
    assign code_vld_o = vld_q;
    assign code_upd_o = upd_q;
    assign err_sat_o  = sat_q;

endmodule

// File: tb/tb_dll_update_ctrl.sv
// Bench for dll_update_ctrl: directed scenarios plus random traffic,
// all outputs compared every cycle against a history-based model.
module tb_dll_update_ctrl;

    localparam int SC = 4;
    localparam int LF = 8;
    localparam int UI = 16;

    localparam int M_UNL  = 0;
    localparam int M_WS   = 1;
    localparam int M_HOLD = 2;
    localparam int M_UPD  = 3;
    localparam int M_TRK  = 4;

    logic       CLKIB = 1'b0;
    logic       resetn;
    logic       lock_i;
    logic [5:0] dcntl_i;
    logic       upd_req_i;
    logic       idle_i;
    logic [4:0] deladj_i;
    logic       deladjpol_i;
    logic       uddcntl_o;
    logic       aluhold_o;
    logic [5:0] code_o;
    logic       code_vld_o;
    logic       code_upd_o;
    logic       lock_o;
    logic       err_sat_o;

    int n_checks = 0;
    int n_errors = 0;

    dll_update_ctrl #(
        .STABLE_CNT      (SC),
        .LOCK_FILTER     (LF),
        .UPDATE_INTERVAL (UI)
    ) dut (
        .CLKIB       (CLKIB),
        .resetn      (resetn),
        .lock_i      (lock_i),
        .dcntl_i     (dcntl_i),
        .upd_req_i   (upd_req_i),
        .idle_i      (idle_i),
        .deladj_i    (deladj_i),
        .deladjpol_i (deladjpol_i),
        .uddcntl_o   (uddcntl_o),
        .aluhold_o   (aluhold_o),
        .code_o      (code_o),
        .code_vld_o  (code_vld_o),
        .code_upd_o  (code_upd_o),
        .lock_o      (lock_o),
        .err_sat_o   (err_sat_o)
    );

    always #5 CLKIB = ~CLKIB;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: lock and stability judged from raw input histories.
    int lhist[0:31];
    int ihist[0:31];
    int m_mode;
    int m_cyc;
    int m_tent;
    int m_code;
    bit m_lock, m_vld, m_upd, m_sat;

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            lhist[k] = 0;
            ihist[k] = 0;
        end
        m_mode = M_UNL;
        m_cyc  = 0;
        m_tent = 0;
        m_code = 0;
        m_lock = 0;
        m_vld  = 0;
        m_upd  = 0;
        m_sat  = 0;
    endtask

    task automatic model_step();
        bit stable;
        int s;
        stable = 1;
        for (int k = 2; k <= SC; k++) begin
            if (ihist[k] != ihist[1]) stable = 0;
        end
        m_upd = 0;
        if (!m_lock) begin
            m_mode = M_UNL;
            m_vld  = 0;
        end else begin
            case (m_mode)
                M_UNL:  m_mode = M_WS;
                M_WS:   if (stable && idle_i) m_mode = M_HOLD;
                M_HOLD: m_mode = M_UPD;
                M_UPD: begin
                    s = deladjpol_i ? ihist[0] - int'(deladj_i)
                                    : ihist[0] + int'(deladj_i);
                    if (s < 0) begin
                        m_code = 0;
                        m_sat  = 1;
                    end else if (s > 63) begin
                        m_code = 63;
                        m_sat  = 1;
                    end else begin
                        m_code = s;
                    end
                    m_vld  = 1;
                    m_upd  = 1;
                    m_mode = M_TRK;
                    m_tent = m_cyc;
                end
                M_TRK: begin
                    if (m_cyc - m_tent == UI || upd_req_i) m_mode = M_WS;
                end
                default: m_mode = M_UNL;
            endcase
        end
        for (int k = 31; k > 0; k--) begin
            lhist[k] = lhist[k-1];
            ihist[k] = ihist[k-1];
        end
        lhist[0] = int'(lock_i);
        ihist[0] = int'(dcntl_i);
        m_lock = 1;
        for (int k = 2; k <= LF + 1; k++) begin
            if (lhist[k] == 0) m_lock = 0;
        end
        m_cyc++;
    endtask

    always @(posedge CLKIB) begin
        if (!resetn) model_reset();
        else model_step();
        #1;
        chk("lock_o", int'(lock_o), int'(m_lock));
        chk("aluhold_o", int'(aluhold_o),
            int'(m_mode == M_HOLD || m_mode == M_UPD));
        chk("uddcntl_o", int'(uddcntl_o), int'(m_mode == M_UPD));
        chk("code_o", int'(code_o), m_code);
        chk("code_vld_o", int'(code_vld_o), int'(m_vld));
        chk("code_upd_o", int'(code_upd_o), int'(m_upd));
        chk("err_sat_o", int'(err_sat_o), int'(m_sat));
    end

    task automatic tick();
        @(negedge CLKIB);
    endtask

    task automatic wait_upd(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            tick();
            n++;
            if (code_upd_o) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL wait_upd: no code_upd_o within %0d cycles", budget);
    endtask

    initial begin
        int n, lat, cnt, code_before, hold_left;
        resetn      = 1'b0;
        lock_i      = 1'b0;
        dcntl_i     = 6'd20;
        upd_req_i   = 1'b0;
        idle_i      = 1'b1;
        deladj_i    = 5'd3;
        deladjpol_i = 1'b0;
        repeat (3) tick();
        chk("rst_code", int'(code_o), 0);
        chk("rst_ctrl", int'({uddcntl_o, aluhold_o, code_vld_o}), 0);
        chk("rst_flags", int'({code_upd_o, lock_o, err_sat_o}), 0);
        resetn = 1'b1;
        repeat (3) tick();

        lock_i = 1'b1;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (lock_o) begin
                lat = k;
                break;
            end
        end
        chk("lock_latency", lat, 10);
        wait_upd(60, n);
        chk("t1_code", int'(code_o), 23);
        chk("t1_sat", int'(err_sat_o), 0);
        tick();
        chk("t1_single_pulse", int'(code_upd_o), 0);

        dcntl_i  = 6'd60;
        deladj_i = 5'd10;
        wait_upd(60, n);
        chk("t2_hi_clamp", int'(code_o), 63);
        chk("t2_sat_set", int'(err_sat_o), 1);
        dcntl_i  = 6'd20;
        deladj_i = 5'd3;
        wait_upd(60, n);
        chk("t2_in_range", int'(code_o), 23);
        chk("t2_sat_sticky", int'(err_sat_o), 1);
        dcntl_i     = 6'd5;
        deladj_i    = 5'd9;
        deladjpol_i = 1'b1;
        wait_upd(60, n);
        chk("t2_lo_clamp", int'(code_o), 0);

        deladj_i    = 5'd0;
        deladjpol_i = 1'b0;
        cnt = 0;
        for (int k = 0; k < 48; k++) begin
            dcntl_i = ((k / 2) % 2 == 0) ? 6'd30 : 6'd31;
            tick();
            if (aluhold_o) cnt++;
        end
        chk("t3_no_hold", cnt, 0);
        dcntl_i = 6'd31;
        wait_upd(60, n);
        chk("t3_commit", int'(code_o), 31);

        wait_upd(60, n);
        chk("t5_interval_gap", n, 19);
        tick();
        tick();
        upd_req_i = 1'b1;
        tick();
        upd_req_i = 1'b0;
        wait_upd(60, n);
        chk("t5_req_gap", n + 3, 6);

        idle_i  = 1'b0;
        dcntl_i = 6'd40;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (uddcntl_o) cnt++;
        end
        chk("t4_no_udd", cnt, 0);
        idle_i = 1'b1;
        tick();
        chk("t4_hold", int'({aluhold_o, uddcntl_o}), 2);
        tick();
        chk("t4_update", int'({aluhold_o, uddcntl_o}), 3);
        tick();
        chk("t4_upd_pulse", int'(code_upd_o), 1);
        chk("t4_code", int'(code_o), 40);

        idle_i = 1'b0;
        repeat (30) tick();
        code_before = int'(code_o);
        lock_i = 1'b0;
        tick();
        idle_i = 1'b1;
        tick();
        chk("t6_hold", int'(aluhold_o), 1);
        tick();
        chk("t6_update_unlk", int'({uddcntl_o, lock_o}), 2);
        tick();
        chk("t6_no_pulse", int'(code_upd_o), 0);
        chk("t6_vld_low", int'(code_vld_o), 0);
        chk("t6_code_held", int'(code_o), code_before);

        lock_i = 1'b1;
        idle_i = 1'b0;
        repeat (20) tick();
        idle_i = 1'b1;
        tick();
        chk("t7_in_hold", int'(aluhold_o), 1);
        resetn = 1'b0;
        #1;
        chk("t7_rst_ctrl", int'({uddcntl_o, aluhold_o}), 0);
        chk("t7_rst_code", int'(code_o), 0);
        chk("t7_rst_flags",
            int'({code_vld_o, code_upd_o, lock_o, err_sat_o}), 0);
        tick();
        resetn = 1'b1;

        hold_left = 0;
        for (int k = 0; k < 3000; k++) begin
            if (lock_i && $urandom_range(0, 299) == 0) lock_i = 1'b0;
            else if (!lock_i && $urandom_range(0, 7) == 0) lock_i = 1'b1;
            if (hold_left == 0) begin
                dcntl_i   = 6'($urandom_range(0, 63));
                hold_left = $urandom_range(1, 12);
            end else begin
                hold_left--;
            end
            deladj_i    = 5'($urandom_range(0, 31));
            deladjpol_i = 1'($urandom_range(0, 1));
            idle_i      = ($urandom_range(0, 9) < 8);
            upd_req_i   = ($urandom_range(0, 99) < 3);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
